// File: rtl/load_store_unit_if.sv
// Datapath-side request/response and memory-side bus of the load/store unit.
// slave is the unit's view; master is the view of whoever drives requests and models memory.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we_req;
  logic [1:0]       size;
  logic             ld_unsigned;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] mem_adr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  modport slave (
    input  req, we_req, size, ld_unsigned, addr, wdata, mem_rd,
    output busy, done, err, rdata, mem_adr, mem_we, mem_wd
  );

  modport master (
    output req, we_req, size, ld_unsigned, addr, wdata, mem_rd,
    input  busy, done, err, rdata, mem_adr, mem_we, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide memory; sub-word stores read-modify-write.
// Done 2 cycles after accept (3 for sub-word stores); busy blocks new requests until back in IDLE.
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 124
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_ERR,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [9:0]       r_addr_q;
  logic [1:0]       r_size_q;
  logic             r_we_q;
  logic             r_uns_q;
  logic             r_err_q;
  logic [WIDTH-1:0] r_wdata_q;
  logic [WIDTH-1:0] r_merge_q;
  logic [WIDTH-1:0] r_rdata;

  logic             w_req_err;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merge;
  logic [WIDTH-1:0] w_mem_adr;
  logic [WIDTH-1:0] w_mem_wd;
  logic             w_mem_we;

  // Checked on the live request inputs so the verdict is ready in the accepting cycle.
  assign w_req_err = (bus.size == 2'b11)
                  || (bus.size == 2'b01 && bus.addr[0])
                  || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
                  || ({2'b00, bus.addr[WIDTH-1:2]} >= WIDTH'(DEPTH));

  assign w_byte = bus.mem_rd[{r_addr_q[1:0], 3'b000} +: 8];
  assign w_half = bus.mem_rd[{r_addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size_q)
      2'b00:   w_load = {{(WIDTH-8){~r_uns_q & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(WIDTH-16){~r_uns_q & w_half[15]}}, w_half};
      default: w_load = bus.mem_rd;
    endcase
  end

  always_comb begin
    w_merge = bus.mem_rd;
    if (r_size_q == 2'b00) begin
      w_merge[{r_addr_q[1:0], 3'b000} +: 8] = r_wdata_q[7:0];
    end else begin
      w_merge[{r_addr_q[1], 4'b0000} +: 16] = r_wdata_q[15:0];
    end
  end

  always_comb begin
    w_next    = r_state;
    w_mem_adr = '0;
    w_mem_wd  = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_req_err)                  w_next = S_ERR;
          else if (!bus.we_req)           w_next = S_LOAD;
          else if (bus.size == 2'b10)     w_next = S_WRITE;
          else                            w_next = S_RMW_RD;
        end
      end
      S_LOAD: begin
        w_mem_adr = {{(WIDTH-8){1'b0}}, r_addr_q[9:2]};
        w_next    = S_DONE;
      end
      S_RMW_RD: begin
        w_mem_adr = {{(WIDTH-8){1'b0}}, r_addr_q[9:2]};
        w_next    = S_WRITE;
      end
      S_WRITE: begin
        w_mem_adr = {{(WIDTH-8){1'b0}}, r_addr_q[9:2]};
        w_mem_wd  = (r_size_q == 2'b10) ? r_wdata_q : r_merge_q;
        w_next    = S_DONE;
      end
      S_ERR:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gated by rst so a reset landing on WRITE never commits a half-finished store.
  assign w_mem_we = (r_state == S_WRITE) && !rst;

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.err     = (r_state == S_DONE) && r_err_q;
  assign bus.rdata   = r_rdata;
  assign bus.mem_adr = w_mem_adr;
  assign bus.mem_we  = w_mem_we;
  assign bus.mem_wd  = w_mem_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_we_q    <= 1'b0;
      r_uns_q   <= 1'b0;
      r_err_q   <= 1'b0;
      r_wdata_q <= '0;
      r_merge_q <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req) begin
        r_addr_q  <= bus.addr[9:0];
        r_size_q  <= bus.size;
        r_we_q    <= bus.we_req;
        r_uns_q   <= bus.ld_unsigned;
        r_wdata_q <= bus.wdata;
        r_err_q   <= w_req_err;
      end
      if (r_state == S_LOAD && !r_we_q) begin
        r_rdata <= w_load;
      end
      if (r_state == S_RMW_RD) begin
        r_merge_q <= w_merge;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a result scoreboard.
// Expected results are queued when a request is driven and compared when done appears.
module tb_load_store_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 124;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(WIDTH)) bus ();
  load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:DEPTH-1];
  logic        pre_we  = 1'b0;
  logic [6:0]  pre_adr = '0;
  logic [31:0] pre_dat = '0;
  int          wr_cnt  = 0;

  assign bus.mem_rd = (bus.mem_adr < DEPTH) ? mem[bus.mem_adr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_adr[6:0]] <= bus.mem_wd;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_adr] <= pre_dat;
    end
  end

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pre_we  = 1'b1;
    pre_adr = idx[6:0];
    pre_dat = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // k counts negedges after the accepting edge N; done seen at k means done at N+k.
  task automatic wait_done(input int start, output int lat, output logic [31:0] adr1);
    lat  = -1;
    adr1 = 32'hFFFF_FFFF;
    for (int k = start; k < start + 10; k++) begin
      @(negedge clk);
      if (k == start) adr1 = bus.mem_adr;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pop_check(input string tag, input int lat, input int w0);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".lat"},   lat,          e.lat);
      check({tag, ".err"},   {31'b0, bus.err}, {31'b0, e.err});
      check({tag, ".rdata"}, bus.rdata,    e.rdata);
      check({tag, ".wr"},    wr_cnt - w0,  e.wr);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] ld_val, input int exp_lat);
    exp_t        e;
    int          w0;
    int          lat;
    logic [31:0] adr1;
    if (!we && !exp_err) model_rdata = ld_val;
    e.err   = exp_err;
    e.rdata = model_rdata;
    e.lat   = exp_lat;
    e.wr    = (we && !exp_err) ? 1 : 0;
    sb.push_back(e);
    w0 = wr_cnt;
    bus.req = 1'b1; bus.we_req = we; bus.size = sz; bus.ld_unsigned = uns;
    bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the live inputs: results must come from the latched copies only.
    bus.req = 1'b0; bus.we_req = ~we; bus.size = 2'b11; bus.ld_unsigned = ~uns;
    bus.addr = 32'hFFFF_FFF3; bus.wdata = 32'h0BAD_F00D;
    wait_done(1, lat, adr1);
    check({tag, ".adr"}, adr1, exp_err ? 32'h0 : {2'b00, a[31:2]});
    pop_check(tag, lat, w0);
    check({tag, ".done_we"},  {31'b0, bus.mem_we}, 32'h0);
    check({tag, ".done_adr"}, bus.mem_adr, 32'h0);
    @(posedge clk);
    #1;
    check({tag, ".idle_busy"}, {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    int          w0;
    int          lat;
    int          lat2;
    logic [31:0] adr1;
    exp_t        e;

    bus.req = 1'b0; bus.we_req = 1'b0; bus.size = 2'b00; bus.ld_unsigned = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.busy",   {31'b0, bus.busy},   32'h0);
    check("rst.done",   {31'b0, bus.done},   32'h0);
    check("rst.err",    {31'b0, bus.err},    32'h0);
    check("rst.mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst.rdata",  bus.rdata,   32'h0);
    check("rst.adr",    bus.mem_adr, 32'h0);
    check("rst.wd",     bus.mem_wd,  32'h0);
    @(posedge clk);
    #1;

    // Word store then word load round trip
    run_req("wst", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    check("wst.mem", mem[4], 32'hDEAD_BEEF);
    run_req("wld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);

    // Sub-word stores merge into the existing word
    preload(4, 32'h1122_3344);
    run_req("bst", 1'b1, 2'b00, 1'b0, 32'h12, 32'h5555_55AA, 1'b0, 32'h0, 3);
    check("bst.mem", mem[4], 32'h11AA_3344);
    preload(5, 32'hCAFE_BABE);
    run_req("hst", 1'b1, 2'b01, 1'b0, 32'h16, 32'h7777_1234, 1'b0, 32'h0, 3);
    check("hst.mem", mem[5], 32'h1234_BABE);

    // Lane extraction and extension
    preload(4, 32'h80FF_7F01);
    run_req("lb0s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_0001, 2);
    run_req("lb1s", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_007F, 2);
    run_req("lb2s", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_FFFF, 2);
    run_req("lb3s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
    run_req("lb3u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 2);
    run_req("lh1u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_80FF, 2);
    run_req("lh1s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_80FF, 2);
    run_req("lh0s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_7F01, 2);

    // Rejected accesses: err, no write, rdata held
    run_req("e_hmis", 1'b0, 2'b01, 1'b0, 32'h11,  32'h0,  1'b1, 32'h0, 2);
    run_req("e_wmis", 1'b1, 2'b10, 1'b0, 32'h16,  32'h99, 1'b1, 32'h0, 2);
    run_req("e_size", 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,  1'b1, 32'h0, 2);
    run_req("e_oor",  1'b0, 2'b10, 1'b0, 32'h1F0, 32'h0,  1'b1, 32'h0, 2);
    run_req("e_oorb", 1'b1, 2'b00, 1'b0, 32'h1F3, 32'h66, 1'b1, 32'h0, 2);
    check("e.mem5", mem[5], 32'h1234_BABE);

    // Last valid word
    preload(123, 32'h0F0E_0D0C);
    run_req("last", 1'b0, 2'b10, 1'b0, 32'h1EC, 32'h0, 1'b0, 32'h0F0E_0D0C, 2);

    // Reset while the byte store is in WRITE
    preload(4, 32'h1122_3344);
    w0 = wr_cnt;
    bus.req = 1'b1; bus.we_req = 1'b1; bus.size = 2'b00; bus.ld_unsigned = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'h99;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1;
    check("rmw.we_before", {31'b0, bus.mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("rmw.we_rst", {31'b0, bus.mem_we}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk);
    check("rmw.busy",  {31'b0, bus.busy}, 32'h0);
    check("rmw.done",  {31'b0, bus.done}, 32'h0);
    check("rmw.adr",   bus.mem_adr, 32'h0);
    check("rmw.rdata", bus.rdata, model_rdata);
    check("rmw.wr",    wr_cnt - w0, 32'h0);
    check("rmw.mem",   mem[4], 32'h1122_3344);
    @(posedge clk);
    #1;

    // req held high across two loads; address changes after the first acceptance
    preload(4, 32'hA5A5_0001);
    preload(5, 32'h5A5A_0002);
    e.err = 1'b0; e.rdata = 32'hA5A5_0001; e.lat = 2; e.wr = 0;
    sb.push_back(e);
    e.rdata = 32'h5A5A_0002; e.lat = 5;
    sb.push_back(e);
    model_rdata = 32'h5A5A_0002;
    w0 = wr_cnt;
    bus.req = 1'b1; bus.we_req = 1'b0; bus.size = 2'b10; bus.ld_unsigned = 1'b0;
    bus.addr = 32'h10;
    @(posedge clk);
    #1 bus.addr = 32'h14;
    wait_done(1, lat, adr1);
    check("held1.adr", adr1, 32'h4);
    pop_check("held1", lat, w0);
    check("held1.busy", {31'b0, bus.busy}, 32'h1);
    @(posedge clk);
    #1;
    check("held.idle", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_done(4, lat2, adr1);
    check("held2.adr", adr1, 32'h5);
    pop_check("held2", lat2, w0);
    @(posedge clk);
    #1;
    check("held.end_busy", {31'b0, bus.busy}, 32'h0);
    check("sb.empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
